branch_update_queue: RTL and testbench
======================================

BRANCH_UPDATE_QUEUE -- requirements
Module: branch_update_queue

Interface
REQ-001 Parameter DEPTH, default 8, SHALL set the number of queue entries; legal values are powers of two from 2 to 64.
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 resetn  input  1  SHALL be the asynchronous, active-low reset.
REQ-004 wr_valid  input  1  SHALL flag a resolved branch offered by execute.
REQ-005 wr_pc  input  32  SHALL carry the resolved branch PC.
REQ-006 wr_target  input  32  SHALL carry the resolved branch target.
REQ-007 wr_type  input  2  SHALL carry the branch type: 2'b01 call, 2'b10 return, 2'b00 other.
REQ-008 wr_taken  input  1  SHALL indicate that the branch resolved taken.
REQ-009 wr_ready  output  1  SHALL indicate that the queue can accept an offer this cycle.
REQ-010 drain_hold  input  1  SHALL block the head from draining this cycle.
REQ-011 flush  input  1  SHALL discard all queued entries.
REQ-012 update_en  output  1  SHALL drive the BTB update strobe.
REQ-013 update_pc, update_BTA  output  32 each  SHALL carry the head entry PC and target.
REQ-014 update_type  output  2  SHALL carry the head entry type.
REQ-015 occupancy  output  log2(DEPTH)+1  SHALL report the stored entry count.

Function
REQ-016 The queue SHALL be a circular FIFO with head pointer, tail pointer and count registers; both pointers SHALL wrap modulo DEPTH.
REQ-017 wr_ready SHALL equal (count != DEPTH), derived from registered count only; a pop in the same cycle SHALL NOT raise it.
REQ-018 An offer SHALL be accepted when wr_valid && wr_ready.
REQ-019 An accepted offer with wr_taken=1 SHALL be written at the tail; an accepted offer with wr_taken=0 SHALL be consumed and discarded without changing any state.
REQ-020 update_en SHALL equal (count != 0) && !drain_hold && !flush; update_pc, update_BTA and update_type SHALL reflect the head entry whenever count != 0, and SHALL be zero when count == 0.
REQ-021 A pop SHALL occur in every cycle in which update_en=1; the BTB has no back-pressure.
REQ-022 Latency: an entry written at edge N SHALL be presented no earlier than the cycle after edge N; there is no write-to-output bypass.
REQ-023 A simultaneous push and pop SHALL leave count unchanged and SHALL advance both pointers.
REQ-024 flush SHALL take priority: at the next edge, count, head and tail SHALL be 0, and any same-cycle offer SHALL be dropped.
REQ-025 Entries SHALL drain in strict arrival order.
REQ-026 occupancy SHALL equal count.

Reset
REQ-027 While resetn=0, count, head and tail SHALL be 0 asynchronously, so that wr_ready=1, update_en=0, update_* = 0 and occupancy=0.
REQ-028 Entry storage SHALL NOT require reset.
REQ-029 Reset asserted mid-operation SHALL discard all entries; the first accepted offer after deassertion SHALL be stored at index 0.

Configuration
REQ-030 With macro BRANCH_UPDATE_QUEUE_COALESCE_EN defined, a taken offer SHALL overwrite the newest entry's target and type in place, with count unchanged, when all of the following hold:
  - count >= 1;
  - the newest entry's PC equals wr_pc;
  - it is not the case that count == 1 and a pop occurs the same cycle (in that case the offer SHALL be allocated normally).
REQ-031 Without the macro, every taken offer SHALL allocate a new entry; wr_ready behaviour SHALL be identical in both builds.

Verification
REQ-032 Reset, then push taken pc=0x100 tgt=0x200 type=01 -> update_en=1 the next cycle with update_pc=0x100, update_BTA=0x200, update_type=01; occupancy 1->0.
REQ-033 Hold drain_hold=1 and push DEPTH taken entries -> occupancy=DEPTH and wr_ready=0; a further offer is not accepted; release drain_hold -> DEPTH strobes in order, one per cycle.
REQ-034 Offer wr_taken=0 pc=0x300 -> accepted (wr_ready=1) but occupancy stays 0 and update_en stays 0.
REQ-035 With occupancy=3, assert flush together with a taken offer -> next cycle occupancy=0, update_en=0, and the offer is absent.
REQ-036 With the macro defined and drain_hold=1, push pc=0x400 tgt=0x500 then pc=0x400 tgt=0x600 -> occupancy=1; after release, one strobe with update_BTA=0x600. Without the macro -> occupancy=2; strobes 0x500 then 0x600.
REQ-037 Assert resetn=0 asynchronously mid-drain with occupancy=4 -> update_en falls without waiting for a clock edge, and occupancy=0.

Source files
------------

// File: rtl/branch_update_queue_if.sv
// Branch update queue interface.
// Carries the execute-side offer channel, the drain controls, and the BTB
// update channel. The queue connects through the slave modport; the
// execute/BTB side (or a bench) connects through the master modport.
`timescale 1ns/1ps

interface branch_update_queue_if #(
  parameter int DEPTH = 8
);
  localparam int CW = $clog2(DEPTH) + 1;

  // Offer channel from execute
  logic          wr_valid;
  logic [31:0]   wr_pc;
  logic [31:0]   wr_target;
  logic [1:0]    wr_type;
  logic          wr_taken;
  logic          wr_ready;

  // Drain controls
  logic          drain_hold;
  logic          flush;

  // BTB update channel
  logic          update_en;
  logic [31:0]   update_pc;
  logic [31:0]   update_BTA;
  logic [1:0]    update_type;
  logic [CW-1:0] occupancy;

  modport master (
    output wr_valid, wr_pc, wr_target, wr_type, wr_taken,
    output drain_hold, flush,
    input  wr_ready,
    input  update_en, update_pc, update_BTA, update_type, occupancy
  );

  modport slave (
    input  wr_valid, wr_pc, wr_target, wr_type, wr_taken,
    input  drain_hold, flush,
    output wr_ready,
    output update_en, update_pc, update_BTA, update_type, occupancy
  );
endinterface

// File: rtl/branch_update_queue.sv
// Branch update queue.
// Circular FIFO buffering taken branches resolved in execute until they can
// be written into the BTB. The head entry is presented every cycle the queue
// is non-empty and not held or flushed; the BTB always accepts, so every
// strobe is a pop. Not-taken offers are accepted and dropped.
//
// Optional feature: define BRANCH_UPDATE_QUEUE_COALESCE_EN to let a taken
// offer whose PC matches the newest entry overwrite that entry's target and
// type in place instead of allocating a new slot.
`timescale 1ns/1ps

module branch_update_queue #(
  parameter int DEPTH = 8
) (
  input  logic                 clk,
  input  logic                 resetn,
  branch_update_queue_if.slave bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  typedef logic [AW-1:0] ptr_t;

  // Entry storage
  logic [31:0] pc_mem   [DEPTH];
  logic [31:0] tgt_mem  [DEPTH];
  logic [1:0]  type_mem [DEPTH];

  // Queue control state
  ptr_t          head_q;
  ptr_t          tail_q;
  logic [CW-1:0] count_q;

  logic not_empty;
  logic accept;
  logic take;
  logic pop;
  logic push;
  logic coalesce;

  // Ready depends only on registered count, so a same-cycle pop never
  // opens a slot for the current offer.
  assign bus.wr_ready = (count_q != FULL_COUNT);
  assign not_empty    = (count_q != '0);
  assign accept       = bus.wr_valid && bus.wr_ready;

  // Flush wins over any same-cycle offer and suppresses the drain.
  assign take = accept && bus.wr_taken && !bus.flush;
  assign pop  = not_empty && !bus.drain_hold && !bus.flush;

`ifdef BRANCH_UPDATE_QUEUE_COALESCE_EN
  ptr_t newest_idx;

  assign newest_idx = tail_q - ptr_t'(1);

  // Merge into the newest entry when it is for the same branch, unless that
  // entry is the only one and is leaving this cycle.
  assign coalesce = take && not_empty
                 && (pc_mem[newest_idx] == bus.wr_pc)
                 && !((count_q == CW'(1)) && pop);
`else
  assign coalesce = 1'b0;
`endif

  assign push = take && !coalesce;

  // Head entry presentation; zeros whenever the queue is empty.
  assign bus.update_en   = pop;
  assign bus.update_pc   = not_empty ? pc_mem[head_q]   : '0;
  assign bus.update_BTA  = not_empty ? tgt_mem[head_q]  : '0;
  assign bus.update_type = not_empty ? type_mem[head_q] : '0;
  assign bus.occupancy   = count_q;

  // Entry storage write: allocate at tail, or merge into the newest entry.
  // NOTE: storage has no reset; validity is tracked by count/pointers only,
  // so clearing the array would cost reset fan-out for no functional gain.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[tail_q]   <= bus.wr_pc;
      tgt_mem[tail_q]  <= bus.wr_target;
      type_mem[tail_q] <= bus.wr_type;
    end
`ifdef BRANCH_UPDATE_QUEUE_COALESCE_EN
    else if (coalesce) begin
      tgt_mem[newest_idx]  <= bus.wr_target;
      type_mem[newest_idx] <= bus.wr_type;
    end
`endif
  end

  // Pointer and count update; pointers wrap naturally at the power-of-two depth.
  // NOTE: all state here uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else if (bus.flush) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (pop)  head_q <= head_q + ptr_t'(1);
      if (push) tail_q <= tail_q + ptr_t'(1);
      unique case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: tb/tb_branch_update_queue.sv
// Self-checking bench for branch_update_queue.
// Stimulus pushes expected BTB updates into a scoreboard queue; a monitor on
// the falling edge pops and compares whenever update_en is seen.
`timescale 1ns/1ps

module tb_branch_update_queue;

  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH) + 1;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] tgt;
    logic [1:0]  typ;
  } entry_t;

  logic clk = 1'b0;
  logic resetn;

  branch_update_queue_if #(.DEPTH(DEPTH)) bus ();

  branch_update_queue #(.DEPTH(DEPTH)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  entry_t exp_q[$];
  entry_t mon_e;
  int     checks   = 0;
  int     failures = 0;
  int     strobes  = 0;
  int     s0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [31:0] pc, input logic [31:0] tgt,
                       input logic [1:0] typ, input logic taken);
    bus.wr_valid  = 1'b1;
    bus.wr_pc     = pc;
    bus.wr_target = tgt;
    bus.wr_type   = typ;
    bus.wr_taken  = taken;
    step();
    bus.wr_valid  = 1'b0;
    bus.wr_taken  = 1'b0;
  endtask

  task automatic expect_entry(input logic [31:0] pc, input logic [31:0] tgt, input logic [1:0] typ);
    exp_q.push_back('{pc: pc, tgt: tgt, typ: typ});
  endtask

  // Monitor: every strobe must match the oldest outstanding expected entry.
  always @(negedge clk) begin
    if (resetn && bus.update_en) begin
      strobes++;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_strobe actual_pc=0x%0h required=no strobe", bus.update_pc);
      end else begin
        mon_e = exp_q.pop_front();
        check("update_pc",   bus.update_pc,   mon_e.pc);
        check("update_BTA",  bus.update_BTA,  mon_e.tgt);
        check("update_type", 32'(bus.update_type), 32'(mon_e.typ));
      end
    end
  end

  initial begin
    resetn         = 1'b0;
    bus.wr_valid   = 1'b0;
    bus.wr_pc      = '0;
    bus.wr_target  = '0;
    bus.wr_type    = '0;
    bus.wr_taken   = 1'b0;
    bus.drain_hold = 1'b0;
    bus.flush      = 1'b0;

    // Reset state
    #2;
    check("rst_wr_ready",    32'(bus.wr_ready),    32'd1);
    check("rst_update_en",   32'(bus.update_en),   32'd0);
    check("rst_occupancy",   32'(bus.occupancy),   32'd0);
    check("rst_update_pc",   bus.update_pc,        32'd0);
    check("rst_update_BTA",  bus.update_BTA,       32'd0);
    check("rst_update_type", 32'(bus.update_type), 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    step();

    // Single taken push, presented the cycle after it is written
    expect_entry(32'h100, 32'h200, 2'b01);
    bus.wr_valid = 1'b1; bus.wr_pc = 32'h100; bus.wr_target = 32'h200;
    bus.wr_type = 2'b01; bus.wr_taken = 1'b1;
    #1;
    check("no_bypass_update_en", 32'(bus.update_en), 32'd0);
    step();
    bus.wr_valid = 1'b0; bus.wr_taken = 1'b0;
    check("single_occ1",      32'(bus.occupancy), 32'd1);
    check("single_update_en", 32'(bus.update_en), 32'd1);
    step();
    check("single_occ0",      32'(bus.occupancy), 32'd0);
    check("empty_update_pc",  bus.update_pc,      32'd0);

    // Not-taken offer is accepted but leaves no trace
    check("nt_wr_ready", 32'(bus.wr_ready), 32'd1);
    offer(32'h300, 32'h340, 2'b00, 1'b0);
    check("nt_occ",       32'(bus.occupancy), 32'd0);
    check("nt_update_en", 32'(bus.update_en), 32'd0);

    // Back-to-back pushes while draining: push+pop keeps count at 1
    for (int i = 0; i < 4; i++) begin
      expect_entry(32'h180 + 32'(i) * 4, 32'h280 + 32'(i) * 8, 2'(i));
      offer(32'h180 + 32'(i) * 4, 32'h280 + 32'(i) * 8, 2'(i), 1'b1);
      check("b2b_occ", 32'(bus.occupancy), 32'd1);
    end
    step();
    check("b2b_occ_end", 32'(bus.occupancy), 32'd0);

    // Fill to DEPTH under drain_hold, then drain in order one per cycle
    bus.drain_hold = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      expect_entry(32'h1000 + 32'(i) * 4, 32'h2000 + 32'(i) * 16, 2'(i % 3));
      offer(32'h1000 + 32'(i) * 4, 32'h2000 + 32'(i) * 16, 2'(i % 3), 1'b1);
    end
    check("full_occ",      32'(bus.occupancy), 32'(DEPTH));
    check("full_wr_ready", 32'(bus.wr_ready),  32'd0);
    offer(32'hDEAD, 32'hBEEF, 2'b01, 1'b1);
    check("full_reject_occ", 32'(bus.occupancy), 32'(DEPTH));
    bus.drain_hold = 1'b0;
    s0 = strobes;
    for (int k = 1; k <= DEPTH; k++) begin
      step();
      check("drain_occ", 32'(bus.occupancy), 32'(DEPTH - k));
    end
    check("drain_strobes", 32'(strobes - s0), 32'(DEPTH));
    check("drain_wr_ready", 32'(bus.wr_ready), 32'd1);

    // Flush with occupancy 3 and a same-cycle taken offer
    bus.drain_hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      expect_entry(32'h700 + 32'(i) * 4, 32'h7100 + 32'(i), 2'b10);
      offer(32'h700 + 32'(i) * 4, 32'h7100 + 32'(i), 2'b10, 1'b1);
    end
    check("pre_flush_occ", 32'(bus.occupancy), 32'd3);
    bus.flush = 1'b1;
    bus.wr_valid = 1'b1; bus.wr_pc = 32'h777; bus.wr_target = 32'h778;
    bus.wr_type = 2'b01; bus.wr_taken = 1'b1;
    step();
    bus.flush = 1'b0; bus.wr_valid = 1'b0; bus.wr_taken = 1'b0;
    exp_q.delete();
    check("flush_occ", 32'(bus.occupancy), 32'd0);
    bus.drain_hold = 1'b0;
    #1;
    check("flush_update_en", 32'(bus.update_en), 32'd0);
    check("flush_wr_ready",  32'(bus.wr_ready),  32'd1);
    expect_entry(32'h880, 32'h990, 2'b00);
    offer(32'h880, 32'h990, 2'b00, 1'b1);
    step();
    check("post_flush_occ", 32'(bus.occupancy), 32'd0);

    // Same-PC pushes: coalesced with the option, separate entries without
    bus.drain_hold = 1'b1;
`ifdef BRANCH_UPDATE_QUEUE_COALESCE_EN
    expect_entry(32'h400, 32'h600, 2'b10);
`else
    expect_entry(32'h400, 32'h500, 2'b01);
    expect_entry(32'h400, 32'h600, 2'b10);
`endif
    offer(32'h400, 32'h500, 2'b01, 1'b1);
    offer(32'h400, 32'h600, 2'b10, 1'b1);
`ifdef BRANCH_UPDATE_QUEUE_COALESCE_EN
    check("same_pc_occ", 32'(bus.occupancy), 32'd1);
`else
    check("same_pc_occ", 32'(bus.occupancy), 32'd2);
`endif
    bus.drain_hold = 1'b0;
    step(); step(); step();
    check("same_pc_drained", 32'(bus.occupancy), 32'd0);

    // Asynchronous reset mid-drain with occupancy 4
    bus.drain_hold = 1'b1;
    for (int i = 0; i < 4; i++) begin
      expect_entry(32'hA00 + 32'(i) * 4, 32'hB00 + 32'(i), 2'b01);
      offer(32'hA00 + 32'(i) * 4, 32'hB00 + 32'(i), 2'b01, 1'b1);
    end
    check("pre_rst_occ", 32'(bus.occupancy), 32'd4);
    bus.drain_hold = 1'b0;
    #1;
    check("pre_rst_update_en", 32'(bus.update_en), 32'd1);
    resetn = 1'b0;
    #1;
    check("async_rst_update_en", 32'(bus.update_en), 32'd0);
    check("async_rst_occ",       32'(bus.occupancy), 32'd0);
    check("async_rst_wr_ready",  32'(bus.wr_ready),  32'd1);
    check("async_rst_update_pc", bus.update_pc,      32'd0);
    exp_q.delete();
    step();
    @(negedge clk);
    resetn = 1'b1;
    step();
    expect_entry(32'h900, 32'h904, 2'b10);
    offer(32'h900, 32'h904, 2'b10, 1'b1);
    check("post_rst_occ", 32'(bus.occupancy), 32'd1);
    step();
    check("post_rst_occ0", 32'(bus.occupancy), 32'd0);

    step();
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
